// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - MSB-first serial pattern transmitter with repeat/gap
// Optional abort input enabled by SERIAL_PATTERN_GEN_ABORT_EN.
module serial_pattern_gen #(
    parameter int PATTERN_W  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int REPS_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [REPS_W-1:0]    reps,
`ifdef SERIAL_PATTERN_GEN_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 a_out,
    output logic                 a_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int BIT_W = $clog2(PATTERN_W);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t               state_q, state_d;
    logic [PATTERN_W-1:0] word_q, word_d;
    logic [PATTERN_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [REPS_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 a_out_q, a_out_d;
    logic                 a_valid_q, a_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 abort_w;

`ifdef SERIAL_PATTERN_GEN_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign start_ready = (state_q == IDLE);
    assign a_out       = a_out_q;
    assign a_valid     = a_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        a_out_d   = 1'b0;
        a_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    word_d    = pattern;
                    shreg_d   = pattern << 1;
                    a_out_d   = pattern[PATTERN_W-1];
                    a_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = BIT_W'(PATTERN_W - 1);
                    rep_cnt_d = (reps == '0) ? REPS_W'(1) : reps;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (bit_cnt_q != '0) begin
                    a_out_d   = shreg_q[PATTERN_W-1];
                    a_valid_d = 1'b1;
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end else if (rep_cnt_q > REPS_W'(1)) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        state_d   = GAP;
                    end else begin
                        // Back-to-back repetition: MSB of the reloaded word follows the LSB directly
                        a_out_d   = word_q[PATTERN_W-1];
                        a_valid_d = 1'b1;
                        shreg_d   = word_q << 1;
                        bit_cnt_d = BIT_W'(PATTERN_W - 1);
                        rep_cnt_d = rep_cnt_q - REPS_W'(1);
                    end
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else begin
                    a_out_d   = word_q[PATTERN_W-1];
                    a_valid_d = 1'b1;
                    shreg_d   = word_q << 1;
                    bit_cnt_d = BIT_W'(PATTERN_W - 1);
                    rep_cnt_d = rep_cnt_q - REPS_W'(1);
                    state_d   = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_w && (state_q != IDLE)) begin
            state_d   = IDLE;
            a_out_d   = 1'b0;
            a_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            a_out_q   <= 1'b0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            a_out_q   <= a_out_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - directed bench for serial_pattern_gen (gap=1 and gap=0 instances)
module tb_serial_pattern_gen;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       sv0, sv1;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic       rdy0, aout0, aval0, busy0, done0;
    logic       rdy1, aout1, aval1, busy1, done1;
`ifdef SERIAL_PATTERN_GEN_ABORT_EN
    logic       abort;
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_pattern_gen #(.PATTERN_W(4), .GAP_CYCLES(1), .REPS_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .start_valid(sv0), .start_ready(rdy0),
        .pattern(pattern), .reps(reps),
`ifdef SERIAL_PATTERN_GEN_ABORT_EN
        .abort(abort),
`endif
        .a_out(aout0), .a_valid(aval0), .busy(busy0), .done(done0)
    );

    serial_pattern_gen #(.PATTERN_W(4), .GAP_CYCLES(0), .REPS_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_valid(sv1), .start_ready(rdy1),
        .pattern(pattern), .reps(reps),
`ifdef SERIAL_PATTERN_GEN_ABORT_EN
        .abort(abort),
`endif
        .a_out(aout1), .a_valid(aval1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs of one instance against an explicit level set
    task automatic check_all(input int sel, input string tag, input logic av, input logic ao,
                             input logic bz, input logic dn, input logic rd);
        check({tag, ".a_valid"},     sel == 0 ? aval0 : aval1, av);
        check({tag, ".a_out"},       sel == 0 ? aout0 : aout1, ao);
        check({tag, ".busy"},        sel == 0 ? busy0 : busy1, bz);
        check({tag, ".done"},        sel == 0 ? done0 : done1, dn);
        check({tag, ".start_ready"}, sel == 0 ? rdy0  : rdy1,  rd);
    endtask

    // '1'/'0' = valid bit, '-' = gap cycle, 'D' = done cycle, 'I' = idle
    task automatic expect_seq(input int sel, input string tag, input string seq);
        byte c;
        for (int i = 0; i < seq.len(); i++) begin
            c = seq[i];
            check_all(sel, $sformatf("%s[%0d]", tag, i),
                      (c == "1") || (c == "0"),
                      (c == "1"),
                      (c == "1") || (c == "0") || (c == "-"),
                      (c == "D"),
                      (c == "D") || (c == "I"));
            step();
        end
    endtask

    task automatic start_job(input int sel, input logic [3:0] pat, input logic [3:0] r);
        pattern = pat;
        reps    = r;
        if (sel == 0) sv0 = 1'b1; else sv1 = 1'b1;
        step();
        if (sel == 0) sv0 = 1'b0; else sv1 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        sv0 = 1'b0;
        sv1 = 1'b0;
        pattern = 4'b0000;
        reps = 4'd0;
`ifdef SERIAL_PATTERN_GEN_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        check_all(0, "reset0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all(1, "reset1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        start_job(0, 4'b1101, 4'd1);
        expect_seq(0, "single", "1101DI");

        start_job(0, 4'b1101, 4'd3);
        expect_seq(0, "gap", "1101-1101-1101DI");

        pattern = 4'b1101;
        reps    = 4'd2;
        sv1     = 1'b1;
        step();
        expect_seq(1, "b2b_a", "11011101D");
        sv1 = 1'b0;
        expect_seq(1, "b2b_b", "11011101DI");

        start_job(0, 4'b1011, 4'd0);
        expect_seq(0, "reps0_a", "10");
        pattern = 4'b0000;
        reps    = 4'd5;
        sv0     = 1'b1;
        expect_seq(0, "busy_req", "1");
        sv0 = 1'b0;
        expect_seq(0, "reps0_b", "1DI");

        start_job(0, 4'b1101, 4'd1);
        expect_seq(0, "rst_pre", "11");
        check_all(0, "rst_bit3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_all(0, "rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        expect_seq(0, "rst_post", "II");
        start_job(0, 4'b0110, 4'd2);
        expect_seq(0, "rst_new", "0110-0110DI");

`ifdef SERIAL_PATTERN_GEN_ABORT_EN
        start_job(0, 4'b1101, 4'd2);
        expect_seq(0, "abort_pre", "1");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_all(0, "abort_now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        expect_seq(0, "abort_post", "II");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
